// File: rtl/btn_pkg.sv
// Shared constants for the pushbutton front end: channel indices and default timing.
package btn_pkg;

    // Number of board pushbuttons.
    localparam int N_BTN = 5;

    // Channel index of each button within btn_raw / btn_level / strobes.
    localparam int BTN_DOWN  = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_F1    = 4;

    // 10 ms of stability at 25 MHz before a change is accepted.
    localparam int DEBOUNCE_CYC_25M = 250000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter, debounced level
// and one-cycle press/release strobes. evt_nxt exposes the strobe next-state so
// the top can register the aggregate change flag on the same edge.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic clk_25m,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls,
    output logic evt_nxt
);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, rls_nxt;

    // Synchronise the asynchronous button into the clock domain.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive cycles the synced input disagrees with the level;
    // any agreeing cycle restarts the count, so bounces never accumulate.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        press_nxt = 1'b0;
        rls_nxt   = 1'b0;
        if (s2 != level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_nxt = s2;
                press_nxt = s2;
                rls_nxt   = ~s2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign evt_nxt = press_nxt | rls_nxt;

    // Debounce state and strobe registers.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rls   <= rls_nxt;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: N_BTN independent debounce channels plus a registered
// change flag that pulses once whenever any channel strobes.
import btn_pkg::*;

module btn_conditioner #(
    parameter int N_BTN        = btn_pkg::N_BTN,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_25M
) (
    input  logic             clk_25m,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             btn_change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [N_BTN-1:0] evt_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk_25m (clk_25m),
            .rst     (rst),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i]),
            .rls     (btn_release[i]),
            .evt_nxt (evt_nxt[i])
        );
    end

    // Aggregate change flag, registered alongside the per-channel strobes.
    always_ff @(posedge clk_25m) begin
        if (rst) btn_change <= 1'b0;
        else     btn_change <= |evt_nxt;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with a short debounce window.
module tb_btn_conditioner;

    localparam int D  = 8;
    localparam int NB = 5;

    logic          clk_25m = 1'b0;
    logic          rst     = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          btn_change;

    int n_checks = 0;
    int n_errors = 0;

    btn_conditioner #(.N_BTN(NB), .DEBOUNCE_CYC(D)) dut (
        .clk_25m     (clk_25m),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_change  (btn_change)
    );

    always #20 clk_25m = ~clk_25m;

    // Reference model: history of sampled raw values. A channel's level flips
    // when the D samples seen two edges ago and earlier all oppose the level.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0;
    logic          m_change = 1'b0;

    always @(posedge clk_25m) begin
        if (rst) begin
            m_level = '0; m_press = '0; m_rel = '0; m_change = 1'b0;
            hist = {};
            for (int k = 0; k < D + 2; k++) hist.push_back('0);
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int ch = 0; ch < NB; ch++) begin
                bit all_opp;
                all_opp = 1'b1;
                for (int k = 0; k < D; k++)
                    if (hist[hist.size() - 2 - k][ch] == m_level[ch]) all_opp = 1'b0;
                if (all_opp) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) m_press[ch] = 1'b1;
                    else             m_rel[ch]   = 1'b1;
                end
            end
            m_change = |(m_press | m_rel);
            hist.push_back(btn_raw);
            if (hist.size() > D + 4) void'(hist.pop_front());
        end
    end

    task automatic test_reset();
        btn_raw = 5'h1F;
        rst     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if ({btn_level, btn_press, btn_release, btn_change} !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d got lvl=%h prs=%h rel=%h chg=%b want all 0",
                         i, btn_level, btn_press, btn_release, btn_change);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if ({btn_level, btn_press, btn_release, btn_change} !== {m_level, m_press, m_rel, m_change}) begin
                n_errors++;
                $display("FAIL reset_model edge=%0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
                         btn_level, btn_press, btn_release, btn_change, m_level, m_press, m_rel, m_change);
            end
            n_checks++;
            if (btn_press !== ((i == 10) ? 5'h1F : 5'h00)) begin
                n_errors++;
                $display("FAIL reset_press edge=%0d got %h want %h", i, btn_press, (i == 10) ? 5'h1F : 5'h00);
            end
        end
        n_checks++;
        if (btn_level !== 5'h1F) begin
            n_errors++;
            $display("FAIL reset_level got %h want 1f", btn_level);
        end
    endtask

    task automatic test_clean_press();
        btn_raw = 5'h00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if ({btn_level, btn_press, btn_release, btn_change} !== {m_level, m_press, m_rel, m_change}) begin
                n_errors++;
                $display("FAIL release_all cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
                         btn_level, btn_press, btn_release, btn_change, m_level, m_press, m_rel, m_change);
            end
        end
        btn_raw = 5'h01;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if ({btn_press, btn_change, btn_level[0]} !== ((i == 10) ? 7'b00001_1_1 :
                                                          (i > 10) ? 7'b00000_0_1 : 7'b00000_0_0)) begin
                n_errors++;
                $display("FAIL clean_press edge=%0d got prs=%h chg=%b lvl0=%b", i,
                         btn_press, btn_change, btn_level[0]);
            end
        end
    endtask

    task automatic test_bounce();
        for (int ph = 0; ph < 4; ph++) begin
            btn_raw[2] = (ph % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk_25m);
                n_checks++;
                if (btn_press[2] !== 1'b0 || btn_level[2] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bounce_quiet ph=%0d got prs2=%b lvl2=%b want 0/0", ph, btn_press[2], btn_level[2]);
                end
            end
        end
        btn_raw[2] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if (btn_press[2] !== (i == 10) || btn_level[2] !== (i >= 10)) begin
                n_errors++;
                $display("FAIL bounce_press edge=%0d got prs2=%b lvl2=%b", i, btn_press[2], btn_level[2]);
            end
        end
    endtask

    task automatic test_short_glitch();
        btn_raw[4] = 1'b1;
        for (int i = 0; i < 7; i++) @(negedge clk_25m);
        btn_raw[4] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if (btn_level[4] !== 1'b0 || btn_press[4] !== 1'b0 || btn_release[4] !== 1'b0) begin
                n_errors++;
                $display("FAIL glitch cyc=%0d got lvl4=%b prs4=%b rel4=%b want 0", i,
                         btn_level[4], btn_press[4], btn_release[4]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int chg_cnt;
        btn_raw = 5'h00;
        for (int i = 0; i < 14; i++) @(negedge clk_25m);
        n_checks++;
        if (btn_level !== 5'h00) begin
            n_errors++;
            $display("FAIL simul_idle got lvl=%h want 00", btn_level);
        end
        for (int dir = 0; dir < 2; dir++) begin
            btn_raw = (dir == 0) ? 5'h0A : 5'h00;
            chg_cnt = 0;
            for (int i = 1; i <= 14; i++) begin
                @(negedge clk_25m);
                if (btn_change) chg_cnt++;
                n_checks++;
                if ((dir == 0 ? btn_press : btn_release) !== ((i == 10) ? 5'h0A : 5'h00)) begin
                    n_errors++;
                    $display("FAIL simul_strobe dir=%0d edge=%0d got prs=%h rel=%h", dir, i, btn_press, btn_release);
                end
            end
            n_checks++;
            if (chg_cnt != 1) begin
                n_errors++;
                $display("FAIL simul_change dir=%0d got %0d cycles want 1", dir, chg_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        btn_raw = 5'h02;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if (btn_press !== 5'h00 || btn_change !== 1'b0) begin
                n_errors++;
                $display("FAIL rstmid_pre cyc=%0d got prs=%h chg=%b want 0", i, btn_press, btn_change);
            end
        end
        rst = 1'b1;
        @(negedge clk_25m);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_25m);
            n_checks++;
            if (btn_press !== ((i == 10) ? 5'h02 : 5'h00)) begin
                n_errors++;
                $display("FAIL rstmid_press edge=%0d got %h want %h", i, btn_press, (i == 10) ? 5'h02 : 5'h00);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) btn_raw = btn_raw ^ NB'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk_25m);
            n_checks++;
            if ({btn_level, btn_press, btn_release, btn_change} !== {m_level, m_press, m_rel, m_change}) begin
                n_errors++;
                $display("FAIL random cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
                         btn_level, btn_press, btn_release, btn_change, m_level, m_press, m_rel, m_change);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
